// File: rtl/cmp_pkg.sv
// Shared types for the chunk-serial magnitude comparator.
// State encoding, 3-way result bundle and chunk-count helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational CHUNK-bit 3-way compare.
// Ripples an "all higher bits equal" term from the MSB downward.
module chunk_compare
    import cmp_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output cmp_res_t         res
);

    logic gt;
    logic lt;
    logic eq_run;

    always_comb begin
        gt     = 1'b0;
        lt     = 1'b0;
        eq_run = 1'b1;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            gt     = gt | (eq_run & a[i] & ~b[i]);
            lt     = lt | (eq_run & ~a[i] & b[i]);
            eq_run = eq_run & ~(a[i] ^ b[i]);
        end
        res.gt = gt;
        res.eq = eq_run;
        res.lt = lt;
    end

endmodule

// File: rtl/seq_mag_compare.sv
// Chunk-serial WIDTH-bit magnitude comparator, MSB chunk first,
// early exit on first unequal chunk, optional two's-complement mode.
module seq_mag_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    input  logic                             is_signed,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             a_gt_b,
    output logic                             a_eq_b,
    output logic                             a_lt_b,
    output logic                             busy,
    output logic [$clog2(WIDTH/CHUNK):0]     cycles
);

    localparam int NCH = nch(WIDTH, CHUNK);
    localparam int CW  = $clog2(NCH) + 1;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(NCH - 1);

    state_t          state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic            mode;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    cmp_res_t        res_q;
    cmp_res_t        cres;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;

    // Offset-binary trick: flipping the sign bit of the top chunk
    // turns a signed compare into an unsigned one.
    always_comb begin
        ca = a_q[32'(idx) * CHUNK +: CHUNK];
        cb = b_q[32'(idx) * CHUNK +: CHUNK];
        if (mode && (idx == TOP_IDX)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
    end

    chunk_compare #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a   (ca),
        .b   (cb),
        .res (cres)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            mode  <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        mode  <= is_signed & (SIGNED_EN != 0);
                        idx   <= TOP_IDX;
                        cnt   <= '0;
                        res_q <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (!cres.eq || (idx == '0)) begin
                        res_q <= cres;
                        state <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        res_q <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign a_gt_b    = res_q.gt;
    assign a_eq_b    = res_q.eq;
    assign a_lt_b    = res_q.lt;
    assign cycles    = cnt;

endmodule

// File: tb/tb_seq_mag_compare.sv
// Self-checking bench: directed cases plus random operands checked
// against an arithmetic reference, on signed-capable and unsigned-only DUTs.
module tb_seq_mag_compare;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic        a_gt_b;
    logic        a_eq_b;
    logic        a_lt_b;
    logic        busy;
    logic [2:0]  cycles;

    logic        in_ready2;
    logic        out_valid2;
    logic        a_gt_b2;
    logic        a_eq_b2;
    logic        a_lt_b2;
    logic        busy2;
    logic [2:0]  cycles2;

    int checks = 0;
    int errors = 0;

    seq_mag_compare #(.WIDTH(16), .CHUNK(4), .SIGNED_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_gt_b    (a_gt_b),
        .a_eq_b    (a_eq_b),
        .a_lt_b    (a_lt_b),
        .busy      (busy),
        .cycles    (cycles)
    );

    seq_mag_compare #(.WIDTH(16), .CHUNK(4), .SIGNED_EN(0)) dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .a_gt_b    (a_gt_b2),
        .a_eq_b    (a_eq_b2),
        .a_lt_b    (a_lt_b2),
        .busy      (busy2),
        .cycles    (cycles2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_flags(input logic [15:0] x, input logic [15:0] y,
                                     input logic s);
        if (s) begin
            if ($signed(x) > $signed(y)) return 4;
            if ($signed(x) < $signed(y)) return 1;
            return 2;
        end
        if (x > y) return 4;
        if (x < y) return 1;
        return 2;
    endfunction

    function automatic int ref_k(input logic [15:0] x, input logic [15:0] y);
        for (int j = 0; j < 4; j++)
            if (((x >> (12 - 4 * j)) & 16'hF) != ((y >> (12 - 4 * j)) & 16'hF))
                return j + 1;
        return 4;
    endfunction

    function automatic int flags(input logic g, input logic e, input logic l);
        return {29'd0, g, e, l};
    endfunction

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb,
                         input logic ts, input int hold);
        int n;
        int k;
        int f1;
        int f2;
        k  = ref_k(ta, tb);
        f1 = ref_flags(ta, tb, ts);
        f2 = ref_flags(ta, tb, 1'b0);
        @(negedge clk);
        a = ta;
        b = tb;
        is_signed = ts;
        in_valid = 1'b1;
        out_ready = 1'b0;
        check("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = (hold > 0);
        check("busy_run", int'(busy), 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, k);
        check("flags", flags(a_gt_b, a_eq_b, a_lt_b), f1);
        check("cycles", int'(cycles), k);
        check("flags_unsigned_dut", flags(a_gt_b2, a_eq_b2, a_lt_b2), f2);
        check("out_valid_unsigned_dut", int'(out_valid2), 1);
        check("in_ready_done", int'(in_ready), 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            a = 16'h0F0F;
            b = 16'hF0F0;
            check("hold_valid", int'(out_valid), 1);
            check("hold_flags", flags(a_gt_b, a_eq_b, a_lt_b), f1);
            check("hold_cycles", int'(cycles), k);
            check("hold_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", int'(out_valid), 0);
        check("release_flags", flags(a_gt_b, a_eq_b, a_lt_b), 0);
        check("release_in_ready", int'(in_ready), 1);
        check("no_second_accept", int'(busy), 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] mask;
        int seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        is_signed = 1'b0;
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_flags", flags(a_gt_b, a_eq_b, a_lt_b), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cycles", int'(cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", int'(in_ready), 1);

        do_op(16'h1234, 16'h1234, 1'b0, 0);
        do_op(16'h8000, 16'h7FFF, 1'b0, 0);
        do_op(16'h8000, 16'h7FFF, 1'b1, 0);
        do_op(16'h12A4, 16'h12B4, 1'b0, 0);
        do_op(16'hFFFF, 16'hFFFE, 1'b0, 0);
        do_op(16'h1234, 16'h1234, 1'b0, 5);
        do_op(16'hFFFF, 16'h0001, 1'b1, 0);

        // abort mid-run: nothing must ever surface afterwards
        @(negedge clk);
        a = 16'h1234;
        b = 16'h1234;
        is_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_flags", flags(a_gt_b, a_eq_b, a_lt_b), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_cycles", int'(cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        check("abort_no_stale", seen, 0);

        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            mask = 16'hF << (4 * $urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = ra;
                2: rb = ra ^ (16'($urandom) & mask);
                default: rb = ra ^ 16'h8000;
            endcase
            do_op(ra, rb, 1'($urandom), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
